// File: rtl/key_repeat_conditioner.sv
// BPM key front end: synchronises and debounces the two raw keys, then turns
// debounced presses into single-cycle inc/dec strobes with accelerating auto-repeat.
module key_repeat_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_SLOW     = 10000000,
   parameter int unsigned REPEAT_FAST     = 2500000,
   parameter int unsigned FAST_AFTER      = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_inc_n,
   input  logic key_dec_n,
   output logic inc_pulse,
   output logic dec_pulse,
   output logic preset_pulse,
   output logic rpt_active
);

   localparam int unsigned RepW = (FAST_AFTER > 0) ? $clog2(FAST_AFTER + 1) : 1;

   localparam logic [31:0]     DebLast   = 32'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0]     DelayLast = 32'(REPEAT_DELAY - 1);
   localparam logic [31:0]     SlowLast  = 32'(REPEAT_SLOW - 1);
   localparam logic [31:0]     FastLast  = 32'(REPEAT_FAST - 1);
   localparam logic [RepW-1:0] RepSat    = RepW'(FAST_AFTER);

   typedef enum logic [1:0] {
      StIdle,
      StHold,
      StWaitRelease
   } state_e;

   // Bit 0 is the increment key, bit 1 the decrement key; all levels active low.
   logic [1:0]       raw_n;
   logic [1:0]       sync1_q;
   logic [1:0]       sync2_q;
   logic [1:0]       deb_n_q;
   logic [1:0]       deb_n_d;
   logic [1:0][31:0] cnt_q;
   logic [1:0][31:0] cnt_d;
   logic [1:0]       pressed;

   state_e           state_q;
   state_e           state_d;
   logic             dir_q;
   logic             dir_d;
   logic [31:0]      timer_q;
   logic [31:0]      timer_d;
   logic [RepW-1:0]  rep_cnt_q;
   logic [RepW-1:0]  rep_cnt_d;
   logic             inc_q;
   logic             inc_d;
   logic             dec_q;
   logic             dec_d;
   logic             preset_q;
   logic             preset_d;
   logic             rpt_q;
   logic             rpt_d;

   logic             held;
   logic             other;
   logic [31:0]      interval_last;

   assign raw_n   = {key_dec_n, key_inc_n};
   assign pressed = ~deb_n_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
      end else begin
         sync1_q <= raw_n;
         sync2_q <= sync1_q;
      end
   end

   // A key change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      deb_n_d = deb_n_q;
      cnt_d   = cnt_q;
      for (int k = 0; k < 2; k++) begin
         if (sync2_q[k] == deb_n_q[k]) begin
            cnt_d[k] = '0;
         end else if (cnt_q[k] == DebLast) begin
            deb_n_d[k] = sync2_q[k];
            cnt_d[k]   = '0;
         end else begin
            cnt_d[k] = cnt_q[k] + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_n_q <= 2'b11;
         cnt_q   <= '0;
      end else begin
         deb_n_q <= deb_n_d;
         cnt_q   <= cnt_d;
      end
   end

   assign held  = dir_q ? pressed[1] : pressed[0];
   assign other = dir_q ? pressed[0] : pressed[1];

   always_comb begin
      if (rep_cnt_q == '0) begin
         interval_last = DelayLast;
      end else if (rep_cnt_q < RepSat) begin
         interval_last = SlowLast;
      end else begin
         interval_last = FastLast;
      end
   end

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      timer_d   = timer_q;
      rep_cnt_d = rep_cnt_q;
      inc_d     = 1'b0;
      dec_d     = 1'b0;
      preset_d  = 1'b0;
      rpt_d     = rpt_q;

      unique case (state_q)
         StIdle: begin
            rpt_d = 1'b0;
            if (&pressed) begin
               preset_d = 1'b1;
               state_d  = StWaitRelease;
            end else if (|pressed) begin
               dir_d     = pressed[1];
               inc_d     = pressed[0];
               dec_d     = pressed[1];
               timer_d   = '0;
               rep_cnt_d = '0;
               state_d   = StHold;
            end
         end

         StHold: begin
            // Chord beats a repeat falling due in the same cycle.
            if (other) begin
               preset_d = 1'b1;
               rpt_d    = 1'b0;
               state_d  = StWaitRelease;
            end else if (!held) begin
               rpt_d   = 1'b0;
               state_d = StIdle;
            end else if (timer_q == interval_last) begin
               inc_d   = ~dir_q;
               dec_d   = dir_q;
               timer_d = '0;
               rpt_d   = 1'b1;
               if (rep_cnt_q != RepSat) begin
                  rep_cnt_d = rep_cnt_q + 1'b1;
               end
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end

         StWaitRelease: begin
            rpt_d = 1'b0;
            if (!(|pressed)) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
            rpt_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         dir_q     <= 1'b0;
         timer_q   <= '0;
         rep_cnt_q <= '0;
         inc_q     <= 1'b0;
         dec_q     <= 1'b0;
         preset_q  <= 1'b0;
         rpt_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         timer_q   <= timer_d;
         rep_cnt_q <= rep_cnt_d;
         inc_q     <= inc_d;
         dec_q     <= dec_d;
         preset_q  <= preset_d;
         rpt_q     <= rpt_d;
      end
   end

   assign inc_pulse    = inc_q;
   assign dec_pulse    = dec_q;
   assign preset_pulse = preset_q;
   assign rpt_active   = rpt_q;

endmodule

// File: tb/tb_key_repeat_conditioner.sv
// Bench for key_repeat_conditioner: cycle-by-cycle comparison against a timing model
// plus literal pulse-time expectations for each directed scenario.
module tb_key_repeat_conditioner;

   localparam int DEB = 4;
   localparam int DLY = 20;
   localparam int SLW = 8;
   localparam int FST = 2;
   localparam int FA  = 3;

   logic clk       = 1'b0;
   logic reset_n   = 1'b0;
   logic key_inc_n = 1'b1;
   logic key_dec_n = 1'b1;
   logic inc_pulse;
   logic dec_pulse;
   logic preset_pulse;
   logic rpt_active;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   key_repeat_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_DELAY   (DLY),
      .REPEAT_SLOW    (SLW),
      .REPEAT_FAST    (FST),
      .FAST_AFTER     (FA)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .key_inc_n   (key_inc_n),
      .key_dec_n   (key_dec_n),
      .inc_pulse   (inc_pulse),
      .dec_pulse   (dec_pulse),
      .preset_pulse(preset_pulse),
      .rpt_active  (rpt_active)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- model ----------------
   bit hist_i[$];
   bit hist_d[$];
   bit m_inc_pr;
   bit m_dec_pr;
   int m_mode;  // 0 idle, 1 holding, 2 waiting for full release
   bit m_dir;   // 1 = decrement
   int m_t0;
   bit e_inc;
   bit e_dec;
   bit e_pre;
   bit e_rpt;

   // Is a repeat due d cycles after the initial strobe?
   function automatic bit repeat_due(input int d);
      int e;
      int span;
      if (d < DLY) return 1'b0;
      e    = d - DLY;
      span = SLW * (FA - 1);
      if (e <= span) return (e % SLW) == 0;
      return ((e - span) % FST) == 0;
   endfunction

   // Debounced state flips when the DEB raw samples taken 2..5 edges ago all show the
   // opposite level (raw 1 = released, so "opposite of pressed" equals the pressed bit).
   function automatic bit flips(input bit q[$], input bit cur_pressed);
      for (int i = 2; i < 2 + DEB; i++) begin
         if (q[q.size() - i] != cur_pressed) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_step();
      bit held;
      bit oth;
      int d;
      if (!reset_n) begin
         hist_i = {};
         hist_d = {};
         for (int i = 0; i < 6; i++) begin
            hist_i.push_back(1'b1);
            hist_d.push_back(1'b1);
         end
         m_inc_pr = 1'b0;
         m_dec_pr = 1'b0;
         m_mode   = 0;
         m_dir    = 1'b0;
         m_t0     = 0;
         e_inc    = 1'b0;
         e_dec    = 1'b0;
         e_pre    = 1'b0;
         e_rpt    = 1'b0;
         return;
      end
      e_inc = 1'b0;
      e_dec = 1'b0;
      e_pre = 1'b0;
      case (m_mode)
         0: begin
            e_rpt = 1'b0;
            if (m_inc_pr && m_dec_pr) begin
               e_pre  = 1'b1;
               m_mode = 2;
            end else if (m_inc_pr || m_dec_pr) begin
               m_dir  = m_dec_pr;
               e_inc  = m_inc_pr;
               e_dec  = m_dec_pr;
               m_t0   = cyc;
               m_mode = 1;
            end
         end
         1: begin
            held = m_dir ? m_dec_pr : m_inc_pr;
            oth  = m_dir ? m_inc_pr : m_dec_pr;
            d    = cyc - m_t0;
            if (oth) begin
               e_pre  = 1'b1;
               e_rpt  = 1'b0;
               m_mode = 2;
            end else if (!held) begin
               e_rpt  = 1'b0;
               m_mode = 0;
            end else begin
               if (repeat_due(d)) begin
                  e_inc = !m_dir;
                  e_dec = m_dir;
               end
               e_rpt = (d >= DLY);
            end
         end
         default: begin
            e_rpt = 1'b0;
            if (!m_inc_pr && !m_dec_pr) m_mode = 0;
         end
      endcase
      if (flips(hist_i, m_inc_pr)) m_inc_pr = !m_inc_pr;
      if (flips(hist_d, m_dec_pr)) m_dec_pr = !m_dec_pr;
      hist_i.push_back(key_inc_n);
      hist_d.push_back(key_dec_n);
      if (hist_i.size() > 12) void'(hist_i.pop_front());
      if (hist_d.size() > 12) void'(hist_d.pop_front());
   endtask

   initial begin
      model_step();
      forever begin
         @(posedge clk or negedge reset_n);
         model_step();
      end
   end

   // ---------------- compare and event log ----------------
   int inc_t[$];
   int dec_t[$];
   int pre_t[$];
   int rpt_rise[$];
   bit rpt_prev = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         chk("inc_pulse vs model", int'(inc_pulse), int'(e_inc));
         chk("dec_pulse vs model", int'(dec_pulse), int'(e_dec));
         chk("preset_pulse vs model", int'(preset_pulse), int'(e_pre));
         chk("rpt_active vs model", int'(rpt_active), int'(e_rpt));
         if (inc_pulse === 1'b1) inc_t.push_back(cyc);
         if (dec_pulse === 1'b1) dec_t.push_back(cyc);
         if (preset_pulse === 1'b1) pre_t.push_back(cyc);
         if (rpt_active === 1'b1 && !rpt_prev) rpt_rise.push_back(cyc);
         rpt_prev = (rpt_active === 1'b1);
      end
   end

   // n-th logged event at or after cycle c, or -1.
   function automatic int nth(input int q[$], input int c, input int n);
      int k = 0;
      foreach (q[i]) begin
         if (q[i] >= c) begin
            if (k == n) return q[i];
            k++;
         end
      end
      return -1;
   endfunction

   function automatic int count_from(input int q[$], input int c);
      int k = 0;
      foreach (q[i]) if (q[i] >= c) k++;
      return k;
   endfunction

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic step_to(input int target);
      while (cyc < target) step(1);
   endtask

   int c0;
   int c1;
   int t0;
   int t1;
   int exp2[6] = '{0, 20, 28, 36, 38, 40};

   initial begin
      step(3);
      chk("reset inc_pulse", int'(inc_pulse), 0);
      chk("reset dec_pulse", int'(dec_pulse), 0);
      chk("reset preset_pulse", int'(preset_pulse), 0);
      chk("reset rpt_active", int'(rpt_active), 0);
      reset_n = 1'b1;
      step(8);

      // 1: bounce then steady press
      c0 = cyc;
      key_inc_n = 1'b0;
      step(3);
      key_inc_n = 1'b1;
      step(5);
      c1 = cyc;
      key_inc_n = 1'b0;
      step(12);
      chk("t1 pulse count", count_from(inc_t, c0), 1);
      chk("t1 press latency", nth(inc_t, c0, 0) - c1, 7);
      key_inc_n = 1'b1;
      step(12);
      chk("t1 no repeat", count_from(inc_t, c0), 1);

      // 2: hold dec 60 cycles
      c0 = cyc;
      key_dec_n = 1'b0;
      step(10);
      t0 = nth(dec_t, c0, 0);
      chk("t2 press latency", t0 - c0, 7);
      step_to(t0 + 60);
      key_dec_n = 1'b1;
      step(15);
      for (int i = 0; i < 6; i++) chk($sformatf("t2 dec pulse %0d", i), nth(dec_t, c0, i) - t0, exp2[i]);
      chk("t2 dec count", count_from(dec_t, c0), 19);
      chk("t2 last dec", nth(dec_t, c0, 18) - t0, 66);
      chk("t2 rpt rise", nth(rpt_rise, c0, 0) - t0, 20);
      chk("t2 rpt low after release", int'(rpt_active), 0);

      // 3: chord during hold
      c0 = cyc;
      key_inc_n = 1'b0;
      step(10);
      t0 = nth(inc_t, c0, 0);
      step_to(t0 + 25);
      key_dec_n = 1'b0;
      step(12);
      chk("t3 preset time", nth(pre_t, c0, 0) - t0, 32);
      chk("t3 inc count", count_from(inc_t, c0), 3);
      chk("t3 dec count", count_from(dec_t, c0), 0);
      key_dec_n = 1'b1;
      step(20);
      chk("t3 inc count after dec release", count_from(inc_t, c0), 3);
      chk("t3 preset count", count_from(pre_t, c0), 1);
      chk("t3 dec count after dec release", count_from(dec_t, c0), 0);
      key_inc_n = 1'b1;
      step(12);
      c1 = cyc;
      key_inc_n = 1'b0;
      step(10);
      chk("t3 re-press latency", nth(inc_t, c1, 0) - c1, 7);
      key_inc_n = 1'b1;
      step(12);

      // 4: simultaneous press
      c0 = cyc;
      key_inc_n = 1'b0;
      key_dec_n = 1'b0;
      step(30);
      chk("t4 preset count", count_from(pre_t, c0), 1);
      chk("t4 preset latency", nth(pre_t, c0, 0) - c0, 7);
      chk("t4 inc count", count_from(inc_t, c0), 0);
      chk("t4 dec count", count_from(dec_t, c0), 0);
      key_inc_n = 1'b1;
      key_dec_n = 1'b1;
      step(12);

      // 5: release during slow repeat, then re-press
      c0 = cyc;
      key_inc_n = 1'b0;
      step(10);
      t0 = nth(inc_t, c0, 0);
      step_to(t0 + 30);
      key_inc_n = 1'b1;
      step(15);
      chk("t5 inc count", count_from(inc_t, c0), 4);
      chk("t5 last inc", nth(inc_t, c0, 3) - t0, 36);
      c1 = cyc;
      key_inc_n = 1'b0;
      step(10);
      t1 = nth(inc_t, c1, 0);
      chk("t5 re-press latency", t1 - c1, 7);
      step_to(t1 + 25);
      chk("t5 first repeat after re-press", nth(inc_t, c1, 1) - t1, 20);
      chk("t5 count after re-press", count_from(inc_t, c1), 2);
      key_inc_n = 1'b1;
      step(12);

      // 6: reset mid-hold with key still held
      c0 = cyc;
      key_inc_n = 1'b0;
      step(10);
      t0 = nth(inc_t, c0, 0);
      step_to(t0 + 22);
      chk("t6 rpt before reset", int'(rpt_active), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6 async rpt_active", int'(rpt_active), 0);
      chk("t6 async inc_pulse", int'(inc_pulse), 0);
      chk("t6 async preset_pulse", int'(preset_pulse), 0);
      step(3);
      reset_n = 1'b1;
      c1 = cyc;
      step(12);
      t1 = nth(inc_t, c1, 0);
      chk("t6 press after reset", t1 - c1, 7);
      step_to(t1 + 25);
      chk("t6 repeat after reset", nth(inc_t, c1, 1) - t1, 20);
      chk("t6 rpt rise after reset", nth(rpt_rise, c1, 0) - t1, 20);
      key_inc_n = 1'b1;
      step(12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/key_repeat_conditioner.md
Name: key_repeat_conditioner

Overview:
- Front-end stage for the metronome's BPM up/down keys: synchronises and debounces KEY1/KEY2.
- Emits single-cycle inc_pulse/dec_pulse strobes with hold-to-repeat auto-acceleration.
- A two-key chord produces a preset_pulse, used by the tempo core to restore default BPM.
- Output strobes feed the tempo core's BPM register directly; no further edge detection downstream.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a key change (20 ms at 50 MHz)
REPEAT_DELAY, 25000000, cycles from initial pulse to first auto-repeat (500 ms)
REPEAT_SLOW, 10000000, repeat interval while repeat count < FAST_AFTER (200 ms)
REPEAT_FAST, 2500000, repeat interval once repeat count >= FAST_AFTER (50 ms)
FAST_AFTER, 8, number of slow repeats before switching to fast interval

Ports:
clk  input  1  system clock, 50 MHz
reset_n  input  1  asynchronous active-low reset
key_inc_n  input  1  raw increment key, active low, asynchronous to clk
key_dec_n  input  1  raw decrement key, active low, asynchronous to clk
inc_pulse  output  1  one-cycle strobe: BPM +1
dec_pulse  output  1  one-cycle strobe: BPM -1
preset_pulse  output  1  one-cycle strobe: both keys chorded
rpt_active  output  1  high while a held key is auto-repeating (after first repeat)

Behaviour:
- Reset: clk and reset_n decided as: reset reset_n, asynchronous, active-low; clock clk. All outputs 0; synchroniser flops 1; debounced states = released; FSM IDLE; all counters 0.
- Sync: 2-FF synchroniser per key.
- Debounce: per-key counter; increments while sync sample != debounced state; clears when equal. On reaching DEBOUNCE_CYCLES, debounced state flips and counter clears.
- Press latency: raw edge to strobe = 2 + DEBOUNCE_CYCLES + 1 cycles.
- Strobes are registered and exactly one cycle wide. At most one of inc_pulse/dec_pulse/preset_pulse is high in any cycle.
- FSM states: IDLE, HOLD, WAIT_RELEASE.
- IDLE:
  - Both debounced presses appear in the same cycle -> preset_pulse, go to WAIT_RELEASE.
  - Only one key pressed -> that key's strobe, latch direction, timer=0, rep_cnt=0, go to HOLD.
- HOLD:
  - Timer increments every cycle.
  - Repeat fires when timer reaches the current interval: strobe in latched direction, timer=0, rep_cnt+1 (saturating at FAST_AFTER), rpt_active=1.
  - Interval = REPEAT_DELAY before the first repeat; thereafter REPEAT_SLOW while rep_cnt < FAST_AFTER, else REPEAT_FAST.
  - Other key's debounced press -> preset_pulse, go to WAIT_RELEASE. This takes priority over a repeat due in the same cycle.
  - Latched key released (and other not pressed) -> IDLE, rpt_active=0, no strobe.
- WAIT_RELEASE: no strobes, rpt_active=0; go to IDLE only when both debounced states are released. A key still held at that point does not generate a press.
- Re-press after IDLE: fresh initial strobe; timing restarts at REPEAT_DELAY.
- Width rules:
  - Timer and debounce counters are 32-bit unsigned; they never wrap, because they clear at their thresholds.
  - rep_cnt is wide enough for FAST_AFTER.
- Reset mid-operation: immediate return to reset state; pending strobe is dropped. A key held across reset deassertion is seen as a new press after full debounce latency.

Test Plan:
Use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_SLOW=8, REPEAT_FAST=2, FAST_AFTER=3 for all scenarios.
1. Bounce: key_inc_n low 3 cycles, high 5, then low steady -> no strobe from the glitch; exactly one inc_pulse, 7 cycles after the steady falling edge.
2. Hold dec 60 cycles from initial strobe at t0 -> dec_pulse at t0, t0+20, t0+28, t0+36, t0+38, t0+40, ...; rpt_active rises at t0+20.
3. Chord: hold inc past first repeat, then press dec -> one preset_pulse, no dec_pulse, no further inc_pulse; release dec only -> still none; release both -> IDLE; re-press inc -> new inc_pulse.
4. Simultaneous press: both keys fall on the same clk edge -> single preset_pulse; inc_pulse and dec_pulse stay 0 throughout.
5. Release inc at t0+30 during slow repeat -> no strobes after release debounce; re-press -> next repeat exactly 20 cycles after the new initial pulse.
6. Assert reset_n low mid-HOLD while inc is still held -> outputs 0 asynchronously; after deassert, inc_pulse 7 cycles later, then repeat timing restarts from REPEAT_DELAY.
